// File: rtl/tape_arb_pkg.sv
// Shared types and defaults for the tape memory arbiter.
//  arb_state_e : arbiter mode, CLEAR (zeroing the tape) or RUN (serving ports)
//  CORE / DBG  : read-return owner tags
package tape_arb_pkg;

   localparam int unsigned ADDR_W_DEF       = 8;
   localparam int unsigned DATA_W_DEF       = 8;
   localparam int unsigned DBG_MAX_WAIT_DEF = 4;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } arb_state_e;

   localparam logic CORE = 1'b0;
   localparam logic DBG  = 1'b1;

endpackage

// File: rtl/tape_mem_arbiter_if.sv
// Bus bundle between the tape arbiter, its two clients and the tape RAM.
//  master : client/RAM side (drives requests, clear_start and mem_rdata)
//  slave  : arbiter side (drives grants, read returns, clear_busy and mem_*)
interface tape_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);
   logic              clear_start;
   logic              clear_busy;

   logic              core_req;
   logic              core_we;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic              core_gnt;
   logic              core_rvalid;
   logic [DATA_W-1:0] core_rdata;

   logic              dbg_req;
   logic [ADDR_W-1:0] dbg_addr;
   logic              dbg_gnt;
   logic              dbg_rvalid;
   logic [DATA_W-1:0] dbg_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output clear_start, core_req, core_we, core_addr, core_wdata,
             dbg_req, dbg_addr, mem_rdata,
      input  clear_busy, core_gnt, core_rvalid, core_rdata,
             dbg_gnt, dbg_rvalid, dbg_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  clear_start, core_req, core_we, core_addr, core_wdata,
             dbg_req, dbg_addr, mem_rdata,
      output clear_busy, core_gnt, core_rvalid, core_rdata,
             dbg_gnt, dbg_rvalid, dbg_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/tape_clear_seq.sv
// Tape clear address sequencer.
//  clk, reset : clock, synchronous active-high reset (restarts the walk at 0)
//  start      : restart the walk at 0
//  advance    : step to the next cell this cycle
//  cnt        : cell currently being cleared
//  done_c     : the last cell is being written this cycle
module tape_clear_seq #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              advance,
   output logic [ADDR_W-1:0] cnt,
   output logic              done_c
);

   // Address walk; wraps to 0 after the last cell so the next clear starts clean
   always_ff @(posedge clk) begin
      if (reset || start) begin
         cnt <= '0;
      end else if (advance) begin
         cnt <= cnt + ADDR_W'(1);
      end
   end

   assign done_c = advance && (cnt == '1);

endmodule

// File: rtl/tape_mem_arbiter.sv
// Single-port tape RAM owner: arbitrates the interpreter core port against a
// read-only debug scanner, and zeroes the whole tape after reset or on request.
//  clk, reset : clock, synchronous active-high reset
//  bus        : tape_mem_arbiter_if.slave (clear control, core port, dbg port, RAM port)
// Optional build macro TAPE_ARB_STARVE_GUARD_EN: dbg wins a contended cycle after
// waiting DBG_MAX_WAIT cycles; otherwise core has strict priority.
module tape_mem_arbiter
   import tape_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned DATA_W       = DATA_W_DEF
`ifdef TAPE_ARB_STARVE_GUARD_EN
   ,
   parameter int unsigned DBG_MAX_WAIT = DBG_MAX_WAIT_DEF
`endif
) (
   input  logic             clk,
   input  logic             reset,
   tape_mem_arbiter_if.slave bus
);

   arb_state_e        state_q;
   logic [ADDR_W-1:0] clr_cnt;
   logic              clr_done_c;
   logic              run_ok;
   logic              force_dbg;
   logic              core_gnt;
   logic              dbg_gnt;
   logic              rd_accept;
   logic              rd_pend_q;
   logic              rd_tag_q;
   logic              core_rvalid;
   logic              dbg_rvalid;
   logic [DATA_W-1:0] core_rdata_q;
   logic [DATA_W-1:0] dbg_rdata_q;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   tape_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
      .clk     (clk),
      .reset   (reset),
      .start   ((state_q == RUN) && bus.clear_start),
      .advance (state_q == CLEAR),
      .cnt     (clr_cnt),
      .done_c  (clr_done_c)
   );

   // Mode FSM: CLEAR walks every cell once, RUN serves the ports
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= CLEAR;
      end else begin
         case (state_q)
            CLEAR:   if (clr_done_c) state_q <= RUN;
            RUN:     if (bus.clear_start) state_q <= CLEAR;
            default: state_q <= CLEAR;
         endcase
      end
   end

`ifdef TAPE_ARB_STARVE_GUARD_EN
   localparam int unsigned WAIT_W = $clog2(DBG_MAX_WAIT + 1);
   logic [WAIT_W-1:0] wait_q;

   // Saturating count of cycles dbg spent requesting without a grant
   always_ff @(posedge clk) begin
      if (reset || dbg_gnt) begin
         wait_q <= '0;
      end else if (bus.dbg_req && (wait_q != WAIT_W'(DBG_MAX_WAIT))) begin
         wait_q <= wait_q + WAIT_W'(1);
      end
   end

   assign force_dbg = (wait_q == WAIT_W'(DBG_MAX_WAIT));
`else
   assign force_dbg = 1'b0;
`endif

   // The clear_start cycle itself issues no grants so the clear begins on a quiet RAM
   assign run_ok    = (state_q == RUN) && !bus.clear_start && !reset;
   assign core_gnt  = run_ok && bus.core_req && !(force_dbg && bus.dbg_req);
   assign dbg_gnt   = run_ok && bus.dbg_req && (!bus.core_req || force_dbg);
   assign rd_accept = (core_gnt && !bus.core_we) || dbg_gnt;

   // RAM port mirrors the clear walk or the granted client
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (reset) begin
         mem_en = 1'b0;
      end else if (state_q == CLEAR) begin
         mem_en   = 1'b1;
         mem_we   = 1'b1;
         mem_addr = clr_cnt;
      end else if (core_gnt) begin
         mem_en    = 1'b1;
         mem_we    = bus.core_we;
         mem_addr  = bus.core_addr;
         mem_wdata = bus.core_wdata;
      end else if (dbg_gnt) begin
         mem_en   = 1'b1;
         mem_addr = bus.dbg_addr;
      end
   end

   // Read return: one pending slot tagged with its owner, data held between returns
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend_q    <= 1'b0;
         rd_tag_q     <= CORE;
         core_rdata_q <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         rd_pend_q <= rd_accept;
         if (rd_accept) rd_tag_q <= dbg_gnt ? DBG : CORE;
         if (core_rvalid) core_rdata_q <= bus.mem_rdata;
         if (dbg_rvalid)  dbg_rdata_q  <= bus.mem_rdata;
      end
   end

   assign core_rvalid = rd_pend_q && (rd_tag_q == CORE) && !reset;
   assign dbg_rvalid  = rd_pend_q && (rd_tag_q == DBG) && !reset;

   assign bus.clear_busy  = reset || (state_q == CLEAR);
   assign bus.core_gnt    = core_gnt;
   assign bus.dbg_gnt     = dbg_gnt;
   assign bus.core_rvalid = core_rvalid;
   assign bus.dbg_rvalid  = dbg_rvalid;
   assign bus.core_rdata  = reset ? '0 : (core_rvalid ? bus.mem_rdata : core_rdata_q);
   assign bus.dbg_rdata   = reset ? '0 : (dbg_rvalid ? bus.mem_rdata : dbg_rdata_q);
   assign bus.mem_en      = mem_en;
   assign bus.mem_we      = mem_we;
   assign bus.mem_addr    = mem_addr;
   assign bus.mem_wdata   = mem_wdata;

endmodule

// File: tb/tb_tape_mem_arbiter.sv
// Testbench for tape_mem_arbiter: directed steps plus a randomized phase checked
// against a behavioural tape model and a registered RAM model.
module tb_tape_mem_arbiter;
   import tape_arb_pkg::*;

   localparam int unsigned AW    = ADDR_W_DEF;
   localparam int unsigned DW    = DATA_W_DEF;
   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned MAXW  = DBG_MAX_WAIT_DEF;
`ifdef TAPE_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [DW-1:0] ram   [DEPTH];
   logic [DW-1:0] model [DEPTH];

   tape_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   tape_mem_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Registered single-port RAM, one-cycle read latency
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata     <= ram[bus.mem_addr];
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.clear_start = 1'b0;
      bus.core_req    = 1'b0;
      bus.core_we     = 1'b0;
      bus.core_addr   = '0;
      bus.core_wdata  = '0;
      bus.dbg_req     = 1'b0;
      bus.dbg_addr    = '0;
   endtask

   // Expects n clear cycles starting at cell 0; the model tape becomes all zero
   task automatic clear_walk(input int n, input string tag);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         #2;
         if (!(bus.mem_en === 1'b1 && bus.mem_we === 1'b1 && bus.mem_addr === AW'(i) &&
               bus.mem_wdata === '0 && bus.clear_busy === 1'b1 &&
               bus.core_gnt === 1'b0 && bus.dbg_gnt === 1'b0)) bad++;
         cyc();
      end
      check(tag, 32'(bad), 32'd0);
      for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
   endtask

   task automatic core_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.core_req   = 1'b1;
      bus.core_we    = 1'b1;
      bus.core_addr  = a;
      bus.core_wdata = d;
      #2;
      check("wr_gnt", 32'(bus.core_gnt), 32'd1);
      cyc();
      bus.core_req = 1'b0;
      bus.core_we  = 1'b0;
      model[a] = d;
   endtask

   task automatic core_read_chk(input logic [AW-1:0] a, input string tag);
      bus.core_req  = 1'b1;
      bus.core_we   = 1'b0;
      bus.core_addr = a;
      #2;
      check({tag, "_gnt"}, 32'(bus.core_gnt), 32'd1);
      cyc();
      bus.core_req = 1'b0;
      #2;
      check({tag, "_rvalid"}, 32'(bus.core_rvalid), 32'd1);
      check({tag, "_rdata"}, 32'(bus.core_rdata), 32'(model[a]));
      cyc();
   endtask

   initial begin
      int          bad;
      int          waitc;
      bit          pc, pd, ch, dh, fd, ec, ed;
      logic [DW-1:0] pcd, pdd;

      for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
      idle_inputs();
      reset = 1'b1;
      bus.core_req = 1'b1;
      bus.dbg_req  = 1'b1;
      repeat (3) cyc();
      #2;
      check("rst_busy",     32'(bus.clear_busy),  32'd1);
      check("rst_mem_en",   32'(bus.mem_en),      32'd0);
      check("rst_core_gnt", 32'(bus.core_gnt),    32'd0);
      check("rst_dbg_gnt",  32'(bus.dbg_gnt),     32'd0);
      check("rst_core_rv",  32'(bus.core_rvalid), 32'd0);
      check("rst_core_rd",  32'(bus.core_rdata),  32'd0);
      check("rst_dbg_rv",   32'(bus.dbg_rvalid),  32'd0);
      cyc();
      idle_inputs();
      reset = 1'b0;

      // Power-on clear: 256 writes of zero, then RUN
      clear_walk(int'(DEPTH), "post_reset_clear");
      #2;
      check("clear_done_busy", 32'(bus.clear_busy), 32'd0);
      cyc();
      core_read_chk(8'h10, "rd_10");

      // Write then immediate read-back
      core_write(8'h05, 8'hA7);
      core_read_chk(8'h05, "rd_05");
      #2;
      check("rvalid_pulse", 32'(bus.core_rvalid), 32'd0);
      check("rdata_hold",   32'(bus.core_rdata),  32'hA7);
      cyc();

      // Contention for 10 cycles: dbg only wins on the 5th/10th with the guard
      bus.core_req  = 1'b1;
      bus.core_we   = 1'b0;
      bus.core_addr = 8'h00;
      bus.dbg_req   = 1'b1;
      bus.dbg_addr  = 8'h03;
      for (int k = 1; k <= 10; k++) begin
         #2;
         check($sformatf("contend_dbg_%0d", k),  32'(bus.dbg_gnt),  32'(GUARD && (k % 5 == 0)));
         check($sformatf("contend_core_%0d", k), 32'(bus.core_gnt), 32'(!(GUARD && (k % 5 == 0))));
         cyc();
      end
      idle_inputs();
      cyc();

      // Pipelined dbg reads
      core_write(8'h00, 8'h11);
      core_write(8'h01, 8'h22);
      core_write(8'h02, 8'h33);
      for (int k = 0; k <= 3; k++) begin
         bus.dbg_req  = (k < 3);
         bus.dbg_addr = AW'(k);
         #2;
         if (k < 3) check($sformatf("dbg_pipe_gnt_%0d", k), 32'(bus.dbg_gnt), 32'd1);
         if (k > 0) begin
            check($sformatf("dbg_pipe_rv_%0d", k), 32'(bus.dbg_rvalid), 32'd1);
            check($sformatf("dbg_pipe_rd_%0d", k), 32'(bus.dbg_rdata),  32'(model[k-1]));
         end
         cyc();
      end
      #2;
      check("dbg_pipe_end", 32'(bus.dbg_rvalid), 32'd0);
      cyc();

      // Randomized traffic against the tape model
      waitc = 0;
      pc = 1'b0; pd = 1'b0; ch = 1'b0; dh = 1'b0;
      pcd = '0; pdd = '0;
      for (int t = 0; t < 300; t++) begin
         if (!ch) begin
            bus.core_req   = ($urandom_range(0, 1) == 1);
            bus.core_we    = ($urandom_range(0, 1) == 1);
            bus.core_addr  = AW'($urandom_range(0, 15));
            bus.core_wdata = DW'($urandom);
         end
         if (!dh) begin
            bus.dbg_req  = ($urandom_range(0, 2) == 0);
            bus.dbg_addr = AW'($urandom_range(0, 15));
         end
         #2;
         fd = GUARD && (waitc >= int'(MAXW));
         ec = bus.core_req && !(fd && bus.dbg_req);
         ed = bus.dbg_req && (!bus.core_req || fd);
         check("rnd_core_gnt", 32'(bus.core_gnt),    32'(ec));
         check("rnd_dbg_gnt",  32'(bus.dbg_gnt),     32'(ed));
         check("rnd_mem_en",   32'(bus.mem_en),      32'(ec || ed));
         check("rnd_core_rv",  32'(bus.core_rvalid), 32'(pc));
         check("rnd_dbg_rv",   32'(bus.dbg_rvalid),  32'(pd));
         if (pc) check("rnd_core_rd", 32'(bus.core_rdata), 32'(pcd));
         if (pd) check("rnd_dbg_rd",  32'(bus.dbg_rdata),  32'(pdd));
         pc  = ec && !bus.core_we;
         pcd = model[bus.core_addr];
         pd  = ed;
         pdd = model[bus.dbg_addr];
         if (ec && bus.core_we) model[bus.core_addr] = bus.core_wdata;
         if (ed) waitc = 0;
         else if (bus.dbg_req && waitc < int'(MAXW)) waitc++;
         ch = bus.core_req && !ec;
         dh = bus.dbg_req && !ed;
         cyc();
      end
      idle_inputs();
      #2;
      check("rnd_tail_core_rv", 32'(bus.core_rvalid), 32'(pc));
      check("rnd_tail_dbg_rv",  32'(bus.dbg_rvalid),  32'(pd));
      cyc();

      // clear_start with a core read in flight
      core_write(8'h40, 8'h5A);
      bus.core_req  = 1'b1;
      bus.core_we   = 1'b0;
      bus.core_addr = 8'h40;
      #2;
      check("inflight_gnt", 32'(bus.core_gnt), 32'd1);
      cyc();
      bus.clear_start = 1'b1;
      #2;
      check("inflight_rv",      32'(bus.core_rvalid), 32'd1);
      check("inflight_rd",      32'(bus.core_rdata),  32'h5A);
      check("clr_start_nognt",  32'(bus.core_gnt),    32'd0);
      check("clr_start_mem_en", 32'(bus.mem_en),      32'd0);
      check("clr_start_busy",   32'(bus.clear_busy),  32'd0);
      cyc();
      idle_inputs();
      clear_walk(int'(DEPTH), "requested_clear");
      #2;
      check("req_clear_done", 32'(bus.clear_busy), 32'd0);
      cyc();

      // Back-to-back sweep: every cell reads zero, no bubbles
      bad = 0;
      for (int a = 0; a <= int'(DEPTH); a++) begin
         bus.core_req  = (a < int'(DEPTH));
         bus.core_addr = AW'(a);
         #2;
         if (a > 0 && !(bus.core_rvalid === 1'b1 && bus.core_rdata === '0)) bad++;
         if (a < int'(DEPTH) && bus.core_gnt !== 1'b1) bad++;
         cyc();
      end
      idle_inputs();
      check("sweep_zero", 32'(bad), 32'd0);

      // Reset during a pending read drops the return
      core_write(8'h07, 8'hC3);
      bus.core_req  = 1'b1;
      bus.core_addr = 8'h07;
      #2;
      check("pre_rst_gnt", 32'(bus.core_gnt), 32'd1);
      cyc();
      idle_inputs();
      reset = 1'b1;
      #2;
      check("rst_drop_rv", 32'(bus.core_rvalid), 32'd0);
      check("rst_drop_rd", 32'(bus.core_rdata),  32'd0);
      cyc();
      reset = 1'b0;

      // Reset at clear count 100 restarts the walk from 0
      clear_walk(100, "clear_head");
      check("at_cnt_100", 32'(bus.mem_addr), 32'd100);
      reset = 1'b1;
      #1;
      check("mid_clear_rst_en", 32'(bus.mem_en), 32'd0);
      cyc();
      reset = 1'b0;
      clear_walk(int'(DEPTH), "clear_restart");
      #2;
      check("restart_done", 32'(bus.clear_busy), 32'd0);
      cyc();
      core_read_chk(8'h07, "rd_07_cleared");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
